// File: rtl/verilog_memcheck_pkg.sv
// Shared types and sizing helpers for the verilog_memcheck streaming pattern checker.
package verilog_memcheck_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    // Value reported when no beat of a run had a mismatch.
    localparam logic [31:0] NoMismatch = 32'hFFFF_FFFF;

    // Bytes carried by one stream beat.
    function automatic int num_bytes(input int data_width);
        return data_width / 8;
    endfunction

    // Width able to hold a per-beat mismatch count of 0..num_bytes.
    function automatic int beat_cnt_width(input int data_width);
        return $clog2(data_width / 8 + 1);
    endfunction

endpackage

// File: rtl/verilog_memcheck_byte_cmp.sv
// Combinational per-beat comparator: counts the bytes of a beat that differ
// from a single pattern byte.
module memcheck_byte_cmp
    import verilog_memcheck_pkg::*;
#(
    parameter int DataWidth = 512
) (
    input  logic [DataWidth-1:0]                  beat,
    input  logic [7:0]                            pattern,
    output logic [beat_cnt_width(DataWidth)-1:0]  mismatches
);

    localparam int NumBytes = num_bytes(DataWidth);
    localparam int CntW     = beat_cnt_width(DataWidth);

    // Popcount of byte lanes that differ from the pattern.
    always_comb begin
        mismatches = '0;
        for (int i = 0; i < NumBytes; i++) begin
            if (beat[8*i +: 8] != pattern) begin
                mismatches = mismatches + CntW'(1);
            end
        end
    end

endmodule

// File: rtl/verilog_memcheck.sv
// Streaming pattern checker: forwards every beat through one register stage
// and, during a started run, counts bytes differing from a programmed pattern
// over N beats. Optional feature macro VERILOG_MEMCHECK_FIRST_IDX_EN builds the
// first-mismatching-beat index register; without it ext_csr_o_1 is constant.
module verilog_memcheck
    import verilog_memcheck_pkg::*;
#(
    parameter int DataWidth  = 512,
    parameter int UserCsrNum = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    output logic                 ext_data_i_ready,
    input  logic                 ext_data_i_valid,
    input  logic [DataWidth-1:0] ext_data_i_bits,
    input  logic                 ext_data_o_ready,
    output logic                 ext_data_o_valid,
    output logic [DataWidth-1:0] ext_data_o_bits,
    input  logic [31:0]          ext_csr_i_0,
    input  logic [31:0]          ext_csr_i_1,
    input  logic                 ext_start_i,
    output logic                 ext_busy_o,
    output logic [31:0]          ext_csr_o_0,
    output logic [31:0]          ext_csr_o_1
);

    localparam int CntW = beat_cnt_width(DataWidth);

    if (DataWidth % 8 != 0) begin : g_bad_width
        $error("DataWidth must be a multiple of 8");
    end
    if (UserCsrNum < 2) begin : g_bad_csr_num
        $error("UserCsrNum must be at least 2");
    end

    logic                 vld_p0;
    logic [DataWidth-1:0] data_p0;
    logic                 accept;
    state_e               state;
    logic [7:0]           pattern;
    logic [31:0]          beat_total;
    logic [31:0]          beat_idx;
    logic [31:0]          mism_total;
    logic [CntW-1:0]      beat_mism;
    logic                 check_beat;
    logic                 unused_csr_bits;

    assign unused_csr_bits = ^ext_csr_i_0[31:8];

    function automatic logic [31:0] sat_add(input logic [31:0] acc, input logic [CntW-1:0] inc);
        logic [32:0] sum;
        sum = {1'b0, acc} + 33'(inc);
        return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
    endfunction

    assign ext_data_i_ready = !vld_p0 || ext_data_o_ready;
    assign accept           = ext_data_i_valid && ext_data_i_ready;
    assign check_beat       = (state == RUN) && accept;

    memcheck_byte_cmp #(
        .DataWidth(DataWidth)
    ) u_byte_cmp (
        .beat       (ext_data_i_bits),
        .pattern    (pattern),
        .mismatches (beat_mism)
    );

    // Stage p0: one-entry pass-through register, loads whenever it can move.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p0  <= 1'b0;
            data_p0 <= '0;
        end else if (ext_data_i_ready) begin
            vld_p0 <= ext_data_i_valid;
            if (ext_data_i_valid) begin
                data_p0 <= ext_data_i_bits;
            end
        end
    end

    assign ext_data_o_valid = vld_p0;
    assign ext_data_o_bits  = data_p0;

    // Run control: start latches CSRs and clears results; RUN counts checked beats.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            pattern    <= '0;
            beat_total <= '0;
            beat_idx   <= '0;
            mism_total <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (ext_start_i) begin
                        pattern    <= ext_csr_i_0[7:0];
                        beat_total <= ext_csr_i_1;
                        beat_idx   <= '0;
                        mism_total <= '0;
                        if (ext_csr_i_1 != 32'd0) begin
                            state <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (accept) begin
                        mism_total <= sat_add(mism_total, beat_mism);
                        beat_idx   <= beat_idx + 32'd1;
                        if (beat_idx == beat_total - 32'd1) begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign ext_busy_o  = (state == RUN);
    assign ext_csr_o_0 = mism_total;

`ifdef VERILOG_MEMCHECK_FIRST_IDX_EN
    logic [31:0] first_idx;

    // Capture the index of the first checked beat with any mismatching byte.
    always_ff @(posedge clk) begin
        if (rst) begin
            first_idx <= NoMismatch;
        end else if (state == IDLE && ext_start_i) begin
            first_idx <= NoMismatch;
        end else if (check_beat && beat_mism != '0 && first_idx == NoMismatch) begin
            first_idx <= beat_idx;
        end
    end

    assign ext_csr_o_1 = first_idx;
`else
    logic unused_check_beat;
    assign unused_check_beat = check_beat;
    assign ext_csr_o_1       = NoMismatch;
`endif

endmodule

// File: tb/tb_verilog_memcheck.sv
// Self-checking bench for verilog_memcheck: a behavioural model tracks the
// expected outputs each cycle, plus literal expectations per directed scenario.
module tb_verilog_memcheck;

    localparam int DW = 512;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          ext_data_i_ready;
    logic          ext_data_i_valid = 1'b0;
    logic [DW-1:0] ext_data_i_bits = '0;
    logic          ext_data_o_ready = 1'b1;
    logic          ext_data_o_valid;
    logic [DW-1:0] ext_data_o_bits;
    logic [31:0]   ext_csr_i_0 = '0;
    logic [31:0]   ext_csr_i_1 = '0;
    logic          ext_start_i = 1'b0;
    logic          ext_busy_o;
    logic [31:0]   ext_csr_o_0;
    logic [31:0]   ext_csr_o_1;

    always #5 clk = ~clk;

    verilog_memcheck #(.DataWidth(DW), .UserCsrNum(2)) dut (
        .clk              (clk),
        .rst              (rst),
        .ext_data_i_ready (ext_data_i_ready),
        .ext_data_i_valid (ext_data_i_valid),
        .ext_data_i_bits  (ext_data_i_bits),
        .ext_data_o_ready (ext_data_o_ready),
        .ext_data_o_valid (ext_data_o_valid),
        .ext_data_o_bits  (ext_data_o_bits),
        .ext_csr_i_0      (ext_csr_i_0),
        .ext_csr_i_1      (ext_csr_i_1),
        .ext_start_i      (ext_start_i),
        .ext_busy_o       (ext_busy_o),
        .ext_csr_o_0      (ext_csr_o_0),
        .ext_csr_o_1      (ext_csr_o_1)
    );

    int n_cmp  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    // Model state, held at reset values until the first edge.
    bit          m_ovalid = 1'b0;
    logic [DW-1:0] m_obits = '0;
    bit          m_busy   = 1'b0;
    logic [31:0] m_count  = 32'd0;
    logic [31:0] m_first  = 32'hFFFF_FFFF;
    logic [31:0] m_idx    = 32'd0;
    logic [31:0] m_left   = 32'd0;
    logic [7:0]  m_pat    = 8'd0;

    function automatic logic [31:0] exp_idx(input logic [31:0] v);
`ifdef VERILOG_MEMCHECK_FIRST_IDX_EN
        return v;
`else
        return 32'hFFFF_FFFF;
`endif
    endfunction

    function automatic logic [DW-1:0] fill(input logic [7:0] b);
        return {64{b}};
    endfunction

    function automatic int bad_bytes(input logic [DW-1:0] d, input logic [7:0] p);
        int n = 0;
        for (int i = 0; i < DW / 8; i++) if (d[8*i +: 8] != p) n++;
        return n;
    endfunction

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checkw(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: what each output must be after this edge, from the stated rules.
    always @(posedge clk) begin
        bit     rdy;
        bit     acc;
        int     nb;
        longint s;
        if (rst) begin
            m_ovalid = 1'b0; m_obits = '0; m_busy = 1'b0;
            m_count = 32'd0; m_first = 32'hFFFF_FFFF; m_idx = 32'd0; m_left = 32'd0;
        end else begin
            rdy = !m_ovalid || ext_data_o_ready;
            acc = ext_data_i_valid && rdy;
            if (m_busy) begin
                if (acc) begin
                    nb = bad_bytes(ext_data_i_bits, m_pat);
                    s = longint'(m_count) + longint'(nb);
                    m_count = (s > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : s[31:0];
                    if (nb != 0 && m_first == 32'hFFFF_FFFF) m_first = m_idx;
                    m_idx++;
                    m_left--;
                    if (m_left == 0) m_busy = 1'b0;
                end
            end else if (ext_start_i) begin
                m_pat = ext_csr_i_0[7:0];
                m_count = 32'd0; m_first = 32'hFFFF_FFFF; m_idx = 32'd0;
                m_left = ext_csr_i_1;
                m_busy = (ext_csr_i_1 != 0);
            end
            if (rdy) begin
                m_ovalid = ext_data_i_valid;
                if (ext_data_i_valid) m_obits = ext_data_i_bits;
            end
        end
    end

    // Compare every cycle, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            check32("ready", 32'(ext_data_i_ready), 32'(!m_ovalid || ext_data_o_ready));
            check32("o_valid", 32'(ext_data_o_valid), 32'(m_ovalid));
            checkw("o_bits", ext_data_o_bits, m_obits);
            check32("busy", 32'(ext_busy_o), 32'(m_busy));
            check32("count", ext_csr_o_0, m_count);
            check32("first_idx", ext_csr_o_1, exp_idx(m_first));
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic start_run(input logic [7:0] pat, input logic [31:0] n);
        ext_csr_i_0 = {24'hABCDEF, pat};
        ext_csr_i_1 = n;
        ext_start_i = 1'b1;
        @(posedge clk); #1;
        ext_start_i = 1'b0;
        ext_csr_i_0 = 32'h0000_00EE;
        ext_csr_i_1 = 32'd7;
    endtask

    task automatic send(input logic [DW-1:0] d);
        bit r;
        int t = 0;
        ext_data_i_valid = 1'b1;
        ext_data_i_bits  = d;
        do begin
            @(negedge clk);
            r = ext_data_i_ready;
            @(posedge clk); #1;
            t++;
        end while (!r && t < 100);
        if (!r) begin
            n_cmp++; n_fail++;
            $display("FAIL send_timeout: beat not accepted within %0d cycles", t);
        end
        ext_data_i_valid = 1'b0;
    endtask

    initial begin
        logic [DW-1:0] b;
        logic [DW-1:0] b0;

        @(posedge clk); #1;
        chk_en = 1'b1;
        idle(1);
        check32("rst_busy", 32'(ext_busy_o), 32'd0);
        check32("rst_count", ext_csr_o_0, 32'd0);
        check32("rst_idx", ext_csr_o_1, 32'hFFFF_FFFF);
        check32("rst_ready", 32'(ext_data_i_ready), 32'd1);
        rst = 1'b0;
        idle(2);

        // Clean run: pattern A5, four clean beats.
        start_run(8'hA5, 32'd4);
        check32("t1_busy_up", 32'(ext_busy_o), 32'd1);
        for (int i = 0; i < 4; i++) send(fill(8'hA5));
        check32("t1_busy_down", 32'(ext_busy_o), 32'd0);
        idle(2);
        check32("t1_count", ext_csr_o_0, 32'd0);
        check32("t1_idx", ext_csr_o_1, 32'hFFFF_FFFF);

        // Two bad bytes in beat 1.
        start_run(8'h00, 32'd3);
        send('0);
        b = '0; b[7:0] = 8'hFF; b[511:504] = 8'hFF;
        send(b);
        checkw("t2_passthru", ext_data_o_bits, b);
        send('0);
        idle(2);
        check32("t2_count", ext_csr_o_0, 32'd2);
        check32("t2_idx", ext_csr_o_1, exp_idx(32'd1));

        // Every byte wrong in both beats.
        start_run(8'h11, 32'd2);
        send(fill(8'h22));
        send(fill(8'h22));
        idle(2);
        check32("t3_count", ext_csr_o_0, 32'd128);
        check32("t3_idx", ext_csr_o_1, exp_idx(32'd0));

        // Backpressure for 5 cycles mid-run.
        start_run(8'h5A, 32'd4);
        b0 = fill(8'h5A);
        send(b0);
        ext_data_o_ready = 1'b0;
        b = fill(8'h5A); b[47:40] = 8'h00;
        fork
            send(b);
            begin
                repeat (5) begin
                    @(negedge clk);
                    check32("bp_ready_low", 32'(ext_data_i_ready), 32'd0);
                    checkw("bp_hold", ext_data_o_bits, b0);
                end
                @(posedge clk); #1;
                ext_data_o_ready = 1'b1;
            end
        join
        b = fill(8'h5A); b[23:0] = 24'h0;
        send(b);
        send(fill(8'h5A));
        idle(2);
        check32("t4_count", ext_csr_o_0, 32'd4);
        check32("t4_idx", ext_csr_o_1, exp_idx(32'd1));

        // Start with N=0 after a failing run clears results only.
        start_run(8'h00, 32'd0);
        check32("t5_busy", 32'(ext_busy_o), 32'd0);
        idle(2);
        check32("t5_count", ext_csr_o_0, 32'd0);
        check32("t5_idx", ext_csr_o_1, 32'hFFFF_FFFF);

        // Reset after 2 of 5 beats, then a fresh one-beat run.
        start_run(8'h00, 32'd5);
        send(fill(8'hFF));
        send(fill(8'hFF));
        check32("t6_mid_count", ext_csr_o_0, 32'd128);
        rst = 1'b1;
        idle(1);
        check32("t6_rst_valid", 32'(ext_data_o_valid), 32'd0);
        checkw("t6_rst_bits", ext_data_o_bits, '0);
        check32("t6_rst_busy", 32'(ext_busy_o), 32'd0);
        check32("t6_rst_count", ext_csr_o_0, 32'd0);
        check32("t6_rst_idx", ext_csr_o_1, 32'hFFFF_FFFF);
        rst = 1'b0;
        idle(1);
        // Dirty beat accepted on the start edge must not be checked.
        ext_csr_i_0 = 32'h0;
        ext_csr_i_1 = 32'd1;
        ext_start_i = 1'b1;
        ext_data_i_valid = 1'b1;
        ext_data_i_bits = fill(8'hFF);
        @(posedge clk); #1;
        ext_start_i = 1'b0;
        ext_data_i_valid = 1'b0;
        send('0);
        idle(2);
        check32("t6_count", ext_csr_o_0, 32'd0);
        check32("t6_idx", ext_csr_o_1, 32'hFFFF_FFFF);
        check32("t6_busy", 32'(ext_busy_o), 32'd0);

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
